// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg : shared constants and helpers for AES plaintext packing     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package aes_pkg;

   localparam int AES_BLOCK_BYTES = 16;

   localparam logic PAD_ZERO  = 1'b0;
   localparam logic PAD_PKCS7 = 1'b1;

   localparam logic [1:0] FILL = 2'd0;
   localparam logic [1:0] PAD  = 2'd1;
   localparam logic [1:0] XPAD = 2'd2;

   // n = bytes already present in the block (0..16)
   function automatic logic [7:0] pkcs7_pad_value(input logic [4:0] n);
      return {3'b000, 5'd16 - n};
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_pad_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pad_gen : keeps the first n bytes of a block, pads the rest      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module aes_pad_gen
   import aes_pkg::*;
(
   input  logic [127:0] block,
   input  logic [4:0]   n,
   input  logic         mode,
   output logic [127:0] padded
);

   logic [7:0] pad_byte;

   assign pad_byte = (mode == PAD_PKCS7) ? pkcs7_pad_value(n) : 8'h00;

   for (genvar i = 0; i < AES_BLOCK_BYTES; i++) begin : g_byte
      assign padded[127-8*i -: 8] = (5'(i) < n) ? block[127-8*i -: 8] : pad_byte;
   end

endmodule
`default_nettype wire

// File: rtl/aes_block_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_block_packer : byte stream -> padded 128-bit plaintext blocks    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module aes_block_packer
   import aes_pkg::*;
#(
   parameter int unsigned PAD_MODE = 1,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [127:0]     blk_data,
   output logic             blk_valid,
   output logic             blk_last,
   input  logic             blk_ready,
   output logic [CNT_W-1:0] blk_cnt,
   output logic             busy
);

   localparam logic MODE_PKCS7 = (PAD_MODE != 0);

   logic [1:0]       state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [127:0]     asm_q, asm_d;
   logic [127:0]     out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             slot_free;
   logic             load;
   logic [127:0]     load_data;
   logic             load_last;
   logic [127:0]     padded;

   assign slot_free = !out_valid_q || blk_ready;

   // While in PAD, idx_q holds the number of bytes stored
   aes_pad_gen u_pad_gen (
      .block  (asm_q),
      .n      ({1'b0, idx_q}),
      .mode   (MODE_PKCS7),
      .padded (padded)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FILL;
         idx_q       <= 4'd0;
         asm_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         asm_q       <= asm_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      asm_d     = asm_q;
      load      = 1'b0;
      load_data = out_data_q;
      load_last = 1'b0;
      case (state_q)
         FILL: begin
            if (in_valid && in_ready) begin
               if (idx_q == 4'd15) begin
                  load      = 1'b1;
                  load_data = {asm_q[127:8], in_data};
                  load_last = in_last && !MODE_PKCS7;
                  idx_d     = 4'd0;
                  asm_d     = '0;
                  if (in_last && MODE_PKCS7) state_d = XPAD;
               end else begin
                  for (int b = 0; b < AES_BLOCK_BYTES; b++) begin
                     if (idx_q == 4'(b)) asm_d[127-8*b -: 8] = in_data;
                  end
                  idx_d = idx_q + 4'd1;
                  if (in_last) state_d = PAD;
               end
            end
         end
         PAD: begin
            if (slot_free) begin
               load      = 1'b1;
               load_data = padded;
               load_last = 1'b1;
               idx_d     = 4'd0;
               asm_d     = '0;
               state_d   = FILL;
            end
         end
         XPAD: begin
            if (slot_free) begin
               load      = 1'b1;
               load_data = {AES_BLOCK_BYTES{8'h10}};
               load_last = 1'b1;
               state_d   = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      if (state_q == FILL) in_ready = (idx_q != 4'd15) || slot_free;
   end

   // A drain and a load in the same cycle leave the register valid with the new block
   always_comb begin
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q && !blk_ready;
      cnt_d       = cnt_q;
      if (out_valid_q && blk_ready) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (load) begin
         out_data_d  = load_data;
         out_last_d  = load_last;
         out_valid_d = 1'b1;
      end
   end

   assign blk_data  = out_data_q;
   assign blk_valid = out_valid_q;
   assign blk_last  = out_last_q;
   assign blk_cnt   = cnt_q;
   assign busy      = (state_q != FILL) || (idx_q != 4'd0) || out_valid_q;

endmodule
`default_nettype wire
